// File: rtl/mwb_pkg.sv
// Shared types and helpers for the MEM/WB segment: load-type encoding, lane width, load extraction.
package mwb_pkg;

  typedef enum logic [2:0] {
    NONE = 3'd0,
    LB   = 3'd1,
    LH   = 3'd2,
    LW   = 3'd3,
    LBU  = 3'd4,
    LHU  = 3'd5,
    LWU  = 3'd6,
    LD   = 3'd7
  } ld_t;

  function automatic int unsigned lane_width(input int unsigned xlen);
    return (xlen == 64) ? 32'd3 : 32'd2;
  endfunction

  // Data is rotated (not shifted) so bytes past the top of the word wrap to lane 0.
  function automatic logic [63:0] extract_load(input ld_t t, input logic [63:0] raw,
                                               input logic [2:0] lane, input logic wide);
    logic [127:0] dbl;
    logic [63:0]  d32;
    logic [63:0]  sh;
    logic [63:0]  res;
    dbl = {raw, raw};
    d32 = {raw[31:0], raw[31:0]};
    if (wide) sh = 64'(dbl >> {lane, 3'b000});
    else      sh = {32'b0, 32'(d32 >> {lane[1:0], 3'b000})};
    res = '0;
    case (t)
      LB:      res = {{56{sh[7]}}, sh[7:0]};
      LH:      res = {{48{sh[15]}}, sh[15:0]};
      LW:      res = wide ? {{32{sh[31]}}, sh[31:0]} : {32'b0, sh[31:0]};
      LBU:     res = {56'b0, sh[7:0]};
      LHU:     res = {48'b0, sh[15:0]};
      LWU:     res = {32'b0, sh[31:0]};
      LD:      res = wide ? sh : {32'b0, sh[31:0]};
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mwb_perf_cnt.sv
// Per-transaction cache hit/miss counters plus miss-cycle counter; built only with PERF_CNT_EN.
module mwb_perf_cnt #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cnt_clr,
  input  logic             access,
  input  logic             is_write,
  input  logic             cache_miss,
  input  logic             stall_req,
  output logic [CNT_W-1:0] rd_hit_cnt,
  output logic [CNT_W-1:0] rd_miss_cnt,
  output logic [CNT_W-1:0] wr_hit_cnt,
  output logic [CNT_W-1:0] wr_miss_cnt,
  output logic [CNT_W-1:0] miss_cyc_cnt
);

  logic             pend_q, pend_d;
  logic [CNT_W-1:0] rd_hit_q, rd_hit_d, rd_miss_q, rd_miss_d;
  logic [CNT_W-1:0] wr_hit_q, wr_hit_d, wr_miss_q, wr_miss_d;
  logic [CNT_W-1:0] miss_cyc_q, miss_cyc_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  always_comb begin
    pend_d     = pend_q;
    rd_hit_d   = rd_hit_q;
    rd_miss_d  = rd_miss_q;
    wr_hit_d   = wr_hit_q;
    wr_miss_d  = wr_miss_q;
    miss_cyc_d = miss_cyc_q;
    if (access && cache_miss) pend_d = 1'b1;
    else if (!cache_miss)     pend_d = 1'b0;
    if (cnt_clr) begin
      rd_hit_d   = '0;
      rd_miss_d  = '0;
      wr_hit_d   = '0;
      wr_miss_d  = '0;
      miss_cyc_d = '0;
    end else begin
      // A transaction is counted once, on the cycle it completes without a miss.
      if (access && !cache_miss) begin
        case ({is_write, pend_q})
          2'b00:   rd_hit_d  = sat_inc(rd_hit_q);
          2'b01:   rd_miss_d = sat_inc(rd_miss_q);
          2'b10:   wr_hit_d  = sat_inc(wr_hit_q);
          default: wr_miss_d = sat_inc(wr_miss_q);
        endcase
      end
      if (stall_req) miss_cyc_d = sat_inc(miss_cyc_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q     <= 1'b0;
      rd_hit_q   <= '0;
      rd_miss_q  <= '0;
      wr_hit_q   <= '0;
      wr_miss_q  <= '0;
      miss_cyc_q <= '0;
    end else begin
      pend_q     <= pend_d;
      rd_hit_q   <= rd_hit_d;
      rd_miss_q  <= rd_miss_d;
      wr_hit_q   <= wr_hit_d;
      wr_miss_q  <= wr_miss_d;
      miss_cyc_q <= miss_cyc_d;
    end
  end

  assign rd_hit_cnt   = rd_hit_q;
  assign rd_miss_cnt  = rd_miss_q;
  assign wr_hit_cnt   = wr_hit_q;
  assign wr_miss_cnt  = wr_miss_q;
  assign miss_cyc_cnt = miss_cyc_q;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB segment register with stall-safe read-data hold and load extraction.
// Optional performance counters are built when PERF_CNT_EN is defined.
module mem_wb_stage
  import mwb_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clear,
  input  logic              cache_miss,
  input  logic [XLEN-1:0]   mem_addr_m,
  input  logic [XLEN/8-1:0] mem_we_m,
  input  logic              mem_to_reg_m,
  input  logic [XLEN-1:0]   cache_rd_data,
  input  logic [XLEN-1:0]   result_m,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [2:0]        reg_write_m,
  output logic              stall_req,
  output logic [XLEN-1:0]   result_w,
  output logic [REG_AW-1:0] rd_w,
  output logic [2:0]        reg_write_w,
  output logic              mem_to_reg_w,
  output logic [XLEN-1:0]   load_data_w
`ifdef PERF_CNT_EN
  ,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  rd_hit_cnt,
  output logic [CNT_W-1:0]  rd_miss_cnt,
  output logic [CNT_W-1:0]  wr_hit_cnt,
  output logic [CNT_W-1:0]  wr_miss_cnt,
  output logic [CNT_W-1:0]  miss_cyc_cnt
`endif
);

  localparam int unsigned LANE_W = lane_width(XLEN);

  logic [XLEN-1:0]   result_q, result_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  ld_t               reg_write_q, reg_write_d;
  logic              mem_to_reg_q, mem_to_reg_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic              hold_q, hold_d;
  logic [XLEN-1:0]   hold_data_q, hold_data_d;
  logic [XLEN-1:0]   raw_data;
  logic              access;
  logic              unused_addr;

  assign unused_addr = ^mem_addr_m[XLEN-1:LANE_W];
  assign access      = mem_to_reg_m | (|mem_we_m);
  assign stall_req   = cache_miss & access;
  assign raw_data    = hold_q ? hold_data_q : cache_rd_data;

  always_comb begin
    result_d     = result_q;
    rd_d         = rd_q;
    reg_write_d  = reg_write_q;
    mem_to_reg_d = mem_to_reg_q;
    lane_d       = lane_q;
    hold_d       = hold_q;
    hold_data_d  = hold_data_q;
    if (!en) begin
      hold_d      = 1'b1;
      hold_data_d = raw_data;
    end else begin
      hold_d = 1'b0;
      if (clear) begin
        result_d     = '0;
        rd_d         = '0;
        reg_write_d  = NONE;
        mem_to_reg_d = 1'b0;
        lane_d       = '0;
      end else begin
        result_d     = result_m;
        rd_d         = rd_m;
        reg_write_d  = ld_t'(reg_write_m);
        mem_to_reg_d = mem_to_reg_m;
        lane_d       = mem_addr_m[LANE_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_q     <= '0;
      rd_q         <= '0;
      reg_write_q  <= NONE;
      mem_to_reg_q <= 1'b0;
      lane_q       <= '0;
      hold_q       <= 1'b0;
      hold_data_q  <= '0;
    end else begin
      result_q     <= result_d;
      rd_q         <= rd_d;
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      lane_q       <= lane_d;
      hold_q       <= hold_d;
      hold_data_q  <= hold_data_d;
    end
  end

  assign result_w     = result_q;
  assign rd_w         = rd_q;
  assign reg_write_w  = reg_write_q;
  assign mem_to_reg_w = mem_to_reg_q;
  assign load_data_w  = XLEN'(extract_load(reg_write_q, 64'(raw_data), 3'(lane_q), XLEN == 64));

`ifdef PERF_CNT_EN
  mwb_perf_cnt #(.CNT_W(CNT_W)) u_perf_cnt (
    .clk          (clk),
    .rst_n        (rst_n),
    .cnt_clr      (cnt_clr),
    .access       (access),
    .is_write     (|mem_we_m),
    .cache_miss   (cache_miss),
    .stall_req    (stall_req),
    .rd_hit_cnt   (rd_hit_cnt),
    .rd_miss_cnt  (rd_miss_cnt),
    .wr_hit_cnt   (wr_hit_cnt),
    .wr_miss_cnt  (wr_miss_cnt),
    .miss_cyc_cnt (miss_cyc_cnt)
  );
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage (XLEN=32); counter checks are compiled when PERF_CNT_EN is defined.
module tb_mem_wb_stage;

  localparam int unsigned CW = 4;

  logic        clk = 1'b0;
  logic        rst_n, en, clear, cache_miss, mem_to_reg_m;
  logic [31:0] mem_addr_m, cache_rd_data, result_m;
  logic [3:0]  mem_we_m;
  logic [4:0]  rd_m;
  logic [2:0]  reg_write_m;
  logic        stall_req, mem_to_reg_w;
  logic [31:0] result_w, load_data_w;
  logic [4:0]  rd_w;
  logic [2:0]  reg_write_w;
`ifdef PERF_CNT_EN
  logic          cnt_clr;
  logic [CW-1:0] rd_hit_cnt, rd_miss_cnt, wr_hit_cnt, wr_miss_cnt, miss_cyc_cnt;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic [2:0]  rw;
    logic        m2r;
    logic [31:0] ld;
  } exp_t;
  exp_t sb_q[$];

  logic [31:0] m_res, m_hdata;
  logic [4:0]  m_rd;
  logic [2:0]  m_rw;
  logic        m_m2r, m_hold;
  logic [1:0]  m_lane;

  mem_wb_stage #(.XLEN(32), .REG_AW(5), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .clear         (clear),
    .cache_miss    (cache_miss),
    .mem_addr_m    (mem_addr_m),
    .mem_we_m      (mem_we_m),
    .mem_to_reg_m  (mem_to_reg_m),
    .cache_rd_data (cache_rd_data),
    .result_m      (result_m),
    .rd_m          (rd_m),
    .reg_write_m   (reg_write_m),
    .stall_req     (stall_req),
    .result_w      (result_w),
    .rd_w          (rd_w),
    .reg_write_w   (reg_write_w),
    .mem_to_reg_w  (mem_to_reg_w),
    .load_data_w   (load_data_w)
`ifdef PERF_CNT_EN
    ,
    .cnt_clr       (cnt_clr),
    .rd_hit_cnt    (rd_hit_cnt),
    .rd_miss_cnt   (rd_miss_cnt),
    .wr_hit_cnt    (wr_hit_cnt),
    .wr_miss_cnt   (wr_miss_cnt),
    .miss_cyc_cnt  (miss_cyc_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference extraction by explicit byte picking with wrap-around lanes.
  function automatic logic [31:0] ref_ld(input logic [2:0] t, input logic [31:0] d, input logic [1:0] l);
    int          li;
    logic [7:0]  b0, b1, b2, b3;
    li = int'(l);
    b0 = 8'(d >> (8 * li));
    b1 = 8'(d >> (8 * ((li + 1) % 4)));
    b2 = 8'(d >> (8 * ((li + 2) % 4)));
    b3 = 8'(d >> (8 * ((li + 3) % 4)));
    case (t)
      3'd1:             return {{24{b0[7]}}, b0};
      3'd2:             return {{16{b1[7]}}, b1, b0};
      3'd4:             return {24'b0, b0};
      3'd5:             return {16'b0, b1, b0};
      3'd3, 3'd6, 3'd7: return {b3, b2, b1, b0};
      default:          return 32'b0;
    endcase
  endfunction

  // One clock: model the edge, push expectation, apply post-edge cache data, pop and compare.
  task automatic step(input logic [31:0] nxt_data);
    logic [31:0] raw;
    exp_t e, g;
    raw = m_hold ? m_hdata : cache_rd_data;
    if (!rst_n) begin
      {m_res, m_rd, m_rw, m_m2r, m_lane, m_hold, m_hdata} = '0;
    end else if (!en) begin
      m_hold = 1'b1;
      m_hdata = raw;
    end else begin
      m_hold = 1'b0;
      if (clear) {m_res, m_rd, m_rw, m_m2r, m_lane} = '0;
      else begin
        m_res = result_m; m_rd = rd_m; m_rw = reg_write_m;
        m_m2r = mem_to_reg_m; m_lane = mem_addr_m[1:0];
      end
    end
    e.res = m_res; e.rd = m_rd; e.rw = m_rw; e.m2r = m_m2r;
    e.ld  = ref_ld(m_rw, m_hold ? m_hdata : nxt_data, m_lane);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    cache_rd_data = nxt_data;
    #1;
    g = sb_q.pop_front();
    chk("result_w", 64'(result_w), 64'(g.res));
    chk("rd_w", 64'(rd_w), 64'(g.rd));
    chk("reg_write_w", 64'(reg_write_w), 64'(g.rw));
    chk("mem_to_reg_w", 64'(mem_to_reg_w), 64'(g.m2r));
    chk("load_data_w", 64'(load_data_w), 64'(g.ld));
  endtask

  task automatic drive_m(input logic ld, input logic [3:0] we, input logic [31:0] addr,
                         input logic [2:0] t, input logic [4:0] rd);
    mem_to_reg_m = ld; mem_we_m = we; mem_addr_m = addr;
    reg_write_m = t; rd_m = rd; result_m = addr ^ 32'hA5A5_0000;
  endtask

  initial begin
    {m_res, m_rd, m_rw, m_m2r, m_lane, m_hold, m_hdata} = '0;
    rst_n = 1'b0; en = 1'b1; clear = 1'b1; cache_miss = 1'b0;
    cache_rd_data = 32'h1234_5678;
`ifdef PERF_CNT_EN
    cnt_clr = 1'b0;
`endif
    drive_m(1'b1, 4'h3, 32'hFFFF_FFFF, 3'd3, 5'd31);
    step(32'h5555_AAAA);
    chk("stall_req_rst", 64'(stall_req), 64'(0));
`ifdef PERF_CNT_EN
    chk("rd_hit_rst", 64'(rd_hit_cnt), 64'(0));
    chk("wr_hit_rst", 64'(wr_hit_cnt), 64'(0));
    chk("miss_cyc_rst", 64'(miss_cyc_cnt), 64'(0));
`endif
    rst_n = 1'b1; clear = 1'b0;

    // Extraction across types and lanes, including wrap at lane 3
    drive_m(1'b1, 4'h0, 32'h1003, 3'd1, 5'd7); step(32'h80FF_0000);
    chk("lb_1003", 64'(load_data_w), 64'(32'hFFFF_FF80));
    drive_m(1'b1, 4'h0, 32'h1003, 3'd4, 5'd8); step(32'h80FF_0000);
    chk("lbu_1003", 64'(load_data_w), 64'(32'h0000_0080));
    drive_m(1'b1, 4'h0, 32'h1002, 3'd2, 5'd9);  step(32'h80FF_0000);
    drive_m(1'b1, 4'h0, 32'h1003, 3'd2, 5'd10); step(32'h80FF_0000);
    drive_m(1'b1, 4'h0, 32'h1001, 3'd5, 5'd11); step(32'h80FF_0000);
    drive_m(1'b1, 4'h0, 32'h1000, 3'd3, 5'd12); step(32'hCAFE_F00D);
    drive_m(1'b1, 4'h0, 32'h1001, 3'd6, 5'd13); step(32'hCAFE_F00D);
    drive_m(1'b1, 4'h0, 32'h1002, 3'd7, 5'd14); step(32'hCAFE_F00D);
    drive_m(1'b0, 4'h0, 32'h1000, 3'd0, 5'd15); step(32'hCAFE_F00D);

    // Stall holds read data while the cache output changes
    drive_m(1'b1, 4'h0, 32'h2000, 3'd3, 5'd3); step(32'h1357_9BDF);
    en = 1'b0;
    drive_m(1'b1, 4'h0, 32'h3001, 3'd1, 5'd4);
    for (int i = 0; i < 5; i++) step(32'hDEAD_BEEF);
    chk("hold_ld", 64'(load_data_w), 64'(32'h1357_9BDF));
    en = 1'b1;
    step(32'h2468_ACE0);

    // Flush with en=1 bubbles; with en=0 it is ignored
    clear = 1'b1; step(32'h0);
    chk("clear_rd", 64'(rd_w), 64'(0));
    clear = 1'b0; drive_m(1'b1, 4'h0, 32'h4002, 3'd5, 5'd21); step(32'h0BAD_F00D);
    en = 1'b0; clear = 1'b1; step(32'h1111_1111);
    chk("clear_hold_rd", 64'(rd_w), 64'(21));
    en = 1'b1; clear = 1'b0;

`ifdef PERF_CNT_EN
    drive_m(1'b0, 4'h0, 32'h0, 3'd0, 5'd0);
    cnt_clr = 1'b1; step(32'h0); cnt_clr = 1'b0;
    // Read miss lasting 4 cycles, then completion
    drive_m(1'b1, 4'h0, 32'h5004, 3'd3, 5'd5);
    cache_miss = 1'b1; en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 chk("stall_miss", 64'(stall_req), 64'(1));
      step(32'h7777_0000);
    end
    cache_miss = 1'b0; en = 1'b1;
    #1 chk("stall_done", 64'(stall_req), 64'(0));
    step(32'h7777_0001);
    drive_m(1'b0, 4'h0, 32'h0, 3'd0, 5'd0); step(32'h0);
    chk("rd_miss_cnt", 64'(rd_miss_cnt), 64'(1));
    chk("miss_cyc_cnt", 64'(miss_cyc_cnt), 64'(4));
    chk("rd_hit_cnt", 64'(rd_hit_cnt), 64'(0));
    chk("wr_hit_cnt", 64'(wr_hit_cnt), 64'(0));
    chk("wr_miss_cnt", 64'(wr_miss_cnt), 64'(0));
    // Saturation then clear-over-increment
    cnt_clr = 1'b1; step(32'h0); cnt_clr = 1'b0;
    drive_m(1'b0, 4'hF, 32'h6000, 3'd0, 5'd0);
    for (int i = 0; i < 17; i++) step(32'h0);
    chk("wr_hit_sat", 64'(wr_hit_cnt), 64'(15));
    cnt_clr = 1'b1; step(32'h0); cnt_clr = 1'b0;
    chk("wr_hit_clr", 64'(wr_hit_cnt), 64'(0));
    drive_m(1'b1, 4'h0, 32'h6004, 3'd3, 5'd1); step(32'h0);
    chk("rd_hit_one", 64'(rd_hit_cnt), 64'(1));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
